// File: rtl/counter_stim_driver.sv
// counter_stim_driver: command-driven stimulus generator and reference model
// for an 8-bit loadable up/down counter. It turns LOAD/UP/DOWN/HOLD commands
// into counter pin activity, models the value data_out must hold each cycle,
// and flags and counts the cycles where the counter disagrees.
module counter_stim_driver #(
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_data,
    output logic             cmd_done,
    output logic             ld_cnt_,
    output logic             count_enb,
    output logic             updn_cnt,
    output logic [7:0]       data_in,
    input  logic [7:0]       data_out,
    output logic [7:0]       exp_out,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int DATA_W = 8;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_HOLD = 2'b11
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] remain_q;
    logic [DATA_W-1:0] remain_d;
    logic              ld_d;
    logic              enb_d;
    logic              updn_d;
    logic [DATA_W-1:0] din_d;
    logic              last_cycle;
    logic              accept;
    logic              is_hold;
    logic              chk_en;
    logic              diff;

    // Saturating increment: the error count sticks at all-ones rather than wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        if (v == {ERR_W{1'b1}})
            return v;
        return v + {{(ERR_W-1){1'b0}}, 1'b1};
    endfunction

    // One counter step, modulo 256 in both directions.
    function automatic logic [DATA_W-1:0] cnt_step(input logic [DATA_W-1:0] v,
                                                   input logic up);
        if (up)
            return v + {{(DATA_W-1){1'b0}}, 1'b1};
        return v - {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    // remain==1 marks the final drive cycle of any command; commands overlap there.
    assign last_cycle = (state_q != S_IDLE) && (remain_q == 8'd1);
    assign cmd_ready  = !rst && ((state_q == S_IDLE) || last_cycle);
    assign cmd_done   = last_cycle;
    assign accept     = cmd_valid && cmd_ready;
    // HOLD, and UP/DOWN with a zero count, both become plain hold cycles.
    assign is_hold    = (cmd_op == OP_HOLD) ||
                        ((cmd_op != OP_LOAD) && (cmd_data == 8'd0));
    assign diff       = (data_out != exp_out);

    // Next-state and next drive values for the command sequencer.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        ld_d     = ld_cnt_;
        enb_d    = count_enb;
        updn_d   = updn_cnt;
        din_d    = data_in;
        if (accept) begin
            if (cmd_op == OP_LOAD) begin
                state_d  = S_LOAD;
                remain_d = 8'd1;
                ld_d     = 1'b0;
                enb_d    = 1'b0;
                din_d    = cmd_data;
            end else if (is_hold) begin
                state_d  = S_HOLD;
                remain_d = (cmd_data == 8'd0) ? 8'd1 : cmd_data;
                ld_d     = 1'b1;
                enb_d    = 1'b0;
                din_d    = 8'd0;
            end else begin
                state_d  = S_RUN;
                remain_d = cmd_data;
                ld_d     = 1'b1;
                enb_d    = 1'b1;
                updn_d   = (cmd_op == OP_UP);
                din_d    = 8'd0;
            end
        end else if ((state_q != S_IDLE) && (remain_q != 8'd1)) begin
            remain_d = remain_q - 8'd1;
        end else begin
            state_d  = S_IDLE;
            remain_d = 8'd0;
            ld_d     = 1'b1;
            enb_d    = 1'b0;
            updn_d   = 1'b0;
            din_d    = 8'd0;
        end
    end

    // Sequencer state and registered counter drive pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            remain_q  <= 8'd0;
            ld_cnt_   <= 1'b1;
            count_enb <= 1'b0;
            updn_cnt  <= 1'b0;
            data_in   <= 8'd0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            ld_cnt_   <= ld_d;
            count_enb <= enb_d;
            updn_cnt  <= updn_d;
            data_in   <= din_d;
        end
    end

    // Reference model: follows the pins exactly as the counter sees them.
    always_ff @(posedge clk) begin
        if (rst)
            exp_out <= 8'd0;
        else if (!ld_cnt_)
            exp_out <= data_in;
        else if (count_enb)
            exp_out <= cnt_step(exp_out, updn_cnt);
    end

    // Compare counter against model; skipped for the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_en   <= 1'b0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else begin
            chk_en   <= 1'b1;
            mismatch <= chk_en && diff;
            if (chk_en && diff)
                err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule

// File: tb/tb_counter_stim_driver.sv
// Bench for counter_stim_driver: a behavioural counter closes the loop on the
// drive pins; expected per-cycle drive values are queued as commands are
// offered and compared each cycle as the driver produces them.
module tb_counter_stim_driver;

    localparam int ERR_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [7:0]       cmd_data = 8'd0;
    logic             cmd_done;
    logic             ld_cnt_;
    logic             count_enb;
    logic             updn_cnt;
    logic [7:0]       data_in;
    logic [7:0]       data_out;
    logic [7:0]       exp_out;
    logic             mismatch;
    logic [ERR_W-1:0] err_cnt;

    logic [7:0]       cnt;
    logic             inject = 1'b0;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       ld_n;
        logic       enb;
        logic       updn;
        logic       keep;
        logic [7:0] din;
        logic       done;
        logic       idle;
    } drv_t;

    localparam drv_t IDLE_T = '{ld_n: 1'b1, enb: 1'b0, updn: 1'b0, keep: 1'b0,
                                din: 8'd0, done: 1'b0, idle: 1'b1};

    drv_t q[$];
    drv_t last_d;
    drv_t cur_d;
    logic [7:0] ref_exp;
    logic       prev_updn;
    logic       e_updn;
    logic       chk_m;
    logic       exp_mis;
    int         err_m;
    int         done_seen = 0;
    int         mis_seen  = 0;

    always #5 clk = ~clk;

    counter_stim_driver #(.ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_done(cmd_done),
        .ld_cnt_(ld_cnt_), .count_enb(count_enb), .updn_cnt(updn_cnt),
        .data_in(data_in), .data_out(data_out), .exp_out(exp_out),
        .mismatch(mismatch), .err_cnt(err_cnt)
    );

    // Behavioural 8-bit loadable up/down counter driven by the DUT pins.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 8'd0;
        else if (!ld_cnt_)
            cnt <= data_in;
        else if (count_enb)
            cnt <= updn_cnt ? cnt + 8'd1 : cnt - 8'd1;
    end
    assign data_out = inject ? (cnt ^ 8'h01) : cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Per-cycle monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            q.delete();
            ref_exp   = 8'd0;
            last_d    = IDLE_T;
            prev_updn = 1'b0;
            chk_m     = 1'b0;
            err_m     = 0;
            chk("rst_ld_cnt_", ld_cnt_, 1'b1);
            chk("rst_count_enb", count_enb, 1'b0);
            chk("rst_updn_cnt", updn_cnt, 1'b0);
            chk("rst_data_in", data_in, 8'd0);
            chk("rst_exp_out", exp_out, 8'd0);
            chk("rst_mismatch", mismatch, 1'b0);
            chk("rst_err_cnt", err_cnt, 0);
            chk("rst_cmd_ready", cmd_ready, 1'b0);
            chk("rst_cmd_done", cmd_done, 1'b0);
        end else begin
            if (!last_d.ld_n)
                ref_exp = last_d.din;
            else if (last_d.enb)
                ref_exp = last_d.updn ? ref_exp + 8'd1 : ref_exp - 8'd1;
            exp_mis = chk_m && inject;
            if (exp_mis && err_m < (2**ERR_W - 1))
                err_m++;
            chk_m = 1'b1;
            cur_d = (q.size() != 0) ? q.pop_front() : IDLE_T;
            e_updn = cur_d.idle ? 1'b0 : (cur_d.keep ? prev_updn : cur_d.updn);
            chk("ld_cnt_", ld_cnt_, cur_d.ld_n);
            chk("count_enb", count_enb, cur_d.enb);
            chk("updn_cnt", updn_cnt, e_updn);
            chk("data_in", data_in, cur_d.din);
            chk("cmd_done", cmd_done, cur_d.done);
            chk("cmd_ready", cmd_ready, cur_d.done || cur_d.idle);
            chk("exp_out", exp_out, ref_exp);
            chk("mismatch", mismatch, exp_mis);
            chk("err_cnt", err_cnt, err_m);
            if (cmd_done)
                done_seen++;
            if (mismatch)
                mis_seen++;
            prev_updn = e_updn;
            last_d    = cur_d;
        end
    end

    // Offer one command; queue its expected drive cycles once it can transfer.
    task automatic issue(input logic [1:0] op, input logic [7:0] n);
        int waited = 0;
        int len;
        drv_t t;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = n;
        while (!cmd_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("cmd_accept", cmd_ready, 1'b1);
        if (cmd_ready) begin
            if (op == 2'b00) begin
                t = '{ld_n: 1'b0, enb: 1'b0, updn: 1'b0, keep: 1'b1,
                      din: n, done: 1'b1, idle: 1'b0};
                q.push_back(t);
            end else if (op == 2'b11 || n == 8'd0) begin
                len = (n == 8'd0) ? 1 : int'(n);
                for (int i = 0; i < len; i++) begin
                    t = '{ld_n: 1'b1, enb: 1'b0, updn: 1'b0, keep: 1'b1,
                          din: 8'd0, done: (i == len - 1), idle: 1'b0};
                    q.push_back(t);
                end
            end else begin
                len = int'(n);
                for (int i = 0; i < len; i++) begin
                    t = '{ld_n: 1'b1, enb: 1'b1, updn: (op == 2'b01), keep: 1'b0,
                          din: 8'd0, done: (i == len - 1), idle: 1'b0};
                    q.push_back(t);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // single load
        issue(2'b00, 8'h5A);
        idle(3);
        chk("load_5a_counter", data_out, 8'h5A);

        // load then up 3, back-to-back, wrapping through zero
        issue(2'b00, 8'hFE);
        issue(2'b01, 8'd3);
        idle(3);
        chk("up_wrap_exp", exp_out, 8'h01);

        // load, down 2 through zero, then hold 4
        issue(2'b00, 8'h01);
        issue(2'b10, 8'd2);
        issue(2'b11, 8'd4);
        idle(3);
        chk("down_wrap_exp", exp_out, 8'hFF);

        // zero-count commands become a single hold cycle; updn kept from UP
        issue(2'b01, 8'd2);
        issue(2'b01, 8'd0);
        issue(2'b10, 8'd0);
        idle(3);
        chk("zero_cnt_exp", exp_out, 8'h01);

        // reset during the second drive cycle of UP 10
        issue(2'b01, 8'd10);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        issue(2'b00, 8'h33);
        issue(2'b01, 8'd2);
        idle(3);
        chk("after_rst_exp", exp_out, 8'h35);

        // three corrupted cycles, then saturation of the error count
        inject = 1'b1;
        idle(3);
        inject = 1'b0;
        idle(2);
        chk("err_cnt_three", err_cnt, 3);
        inject = 1'b1;
        idle(5);
        inject = 1'b0;
        idle(2);
        chk("err_cnt_sat", err_cnt, 7);
        chk("mismatch_pulses", mis_seen, 8);
        chk("done_pulses", done_seen, 11);
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
